// File: rtl/yavg_bin_if.sv
// Luma-in / binarised-pixel-out bundle between the RGB-to-luma converter,
// yavg_bin, and the downstream binary-image stages.
interface yavg_bin_if;
   logic        y__ready;
   logic [15:0] y;
   logic        flush;
   logic        pix__ready;
   logic [7:0]  pix;
   logic        bin;
   logic        full;
   logic        ovf;

   modport master (
      output y__ready, y, flush,
      input  pix__ready, pix, bin, full, ovf
   );

   modport slave (
      input  y__ready, y, flush,
      output pix__ready, pix, bin, full, ovf
   );
endinterface

// File: rtl/yavg_bin.sv
// Luma normaliser with saturation, 4-sample moving average and threshold binariser.
// One sample is processed in four edges: IDLE -> NORM -> ACC -> OUT.
module yavg_bin #(
   parameter int unsigned SHIFT  = 5,
   parameter int unsigned THRESH = 128
) (
   input  logic       clk,
   input  logic       rst,
   yavg_bin_if.slave  bus
);

   localparam logic [7:0] ThreshB = THRESH[7:0];

   typedef enum logic [1:0] {StIdle, StNorm, StAcc, StOut} state_e;

   state_e      state_q, state_d;
   logic [15:0] ybuf_q;
   logic [7:0]  y8_q;
   logic [7:0]  w0_q, w1_q, w2_q, w3_q;
   logic [9:0]  sum_q;
   logic [2:0]  fill_q;
   logic        full_q;
   logic        ovf_q;
   logic [7:0]  pix_q;
   logic        bin_q;
   logic        pix_ready_q;

   logic [15:0] t;
   logic [7:0]  y8_sat;
   logic [9:0]  sum_next;
   logic [2:0]  fill_inc;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.y__ready) state_d = StNorm;
         StNorm:  state_d = StAcc;
         StAcc:   state_d = StOut;
         StOut:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      t        = ybuf_q >> SHIFT;
      y8_sat   = (t > 16'd255) ? 8'd255 : t[7:0];
      // Window slots start at zero, so the running sum never exceeds 4*255.
      sum_next = sum_q + {2'b00, y8_q} - {2'b00, w3_q};
      fill_inc = fill_q + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ybuf_q      <= '0;
         y8_q        <= '0;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         w3_q        <= '0;
         sum_q       <= '0;
         fill_q      <= '0;
         full_q      <= 1'b0;
         ovf_q       <= 1'b0;
         pix_q       <= '0;
         bin_q       <= 1'b0;
         pix_ready_q <= 1'b0;
      end else begin
         pix_ready_q <= 1'b0;
         // A sample arriving mid-operation is dropped and flagged.
         if (bus.y__ready && (state_q != StIdle)) ovf_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (bus.y__ready) begin
                  ybuf_q <= bus.y;
               end else if (bus.flush) begin
                  w0_q   <= '0;
                  w1_q   <= '0;
                  w2_q   <= '0;
                  w3_q   <= '0;
                  sum_q  <= '0;
                  fill_q <= '0;
                  full_q <= 1'b0;
               end
            end
            StNorm: y8_q <= y8_sat;
            StAcc: begin
               sum_q  <= sum_next;
               w3_q   <= w2_q;
               w2_q   <= w1_q;
               w1_q   <= w0_q;
               w0_q   <= y8_q;
               fill_q <= (fill_inc > 3'd4) ? 3'd4 : fill_inc;
               full_q <= (fill_inc >= 3'd4);
            end
            StOut: begin
               pix_q       <= sum_q[9:2];
               bin_q       <= (sum_q[9:2] >= ThreshB);
               pix_ready_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.pix__ready = pix_ready_q;
   assign bus.pix        = pix_q;
   assign bus.bin        = bin_q;
   assign bus.full       = full_q;
   assign bus.ovf        = ovf_q;

endmodule
